// File: rtl/if_inst_queue.sv
// Instruction queue between IF and ID.
// Buffers up to DEPTH fetch packets {inst, pc, adef} in program order and
// presents the oldest one to ID under a valid/allow handshake. Any redirect
// (exception, ertn, taken branch) empties the queue and drops the packet
// IF is offering in the same cycle.
module if_inst_queue #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             IF_to_IQ_valid,
    input  logic [64:0]      IF_to_IQ_bus,
    output logic             IQ_allow,
    output logic             IQ_to_ID_valid,
    output logic [64:0]      IQ_to_ID_bus,
    input  logic             ID_allow,
    input  logic             WB_exception,
    input  logic             ertn_flush,
    input  logic             branch_valid,
    output logic [PTR_W:0]   IQ_count
);

    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [64:0]      mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             rst_done;
    logic             flush;
    logic             push;
    logic             pop;

    // Occupancy comes only from count: head==tail is ambiguous between
    // full and empty. IQ_allow is deliberately independent of ID_allow, so a
    // full queue refuses a packet even in a cycle where it pops one.
    assign flush          = WB_exception | ertn_flush | branch_valid;
    assign IQ_allow       = rst_done & (count != COUNT_FULL);
    assign push           = IF_to_IQ_valid & IQ_allow & ~flush;
    assign IQ_to_ID_valid = (count != '0) & ~flush;
    assign IQ_to_ID_bus   = (count != '0) ? mem[head] : '0;
    assign pop            = IQ_to_ID_valid & ID_allow;
    assign IQ_count       = count;

    // Marks the first clock after reset release; keeps IF blocked while reset is held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    // Head/tail/count bookkeeping; a flush wins over any push or pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Packet storage; not reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= IF_to_IQ_bus;
        end
    end

endmodule

// File: tb/tb_if_inst_queue.sv
// Directed bench for if_inst_queue (DEPTH=4) with hand-computed expectations.
module tb_if_inst_queue;

    logic        clk;
    logic        resetn;
    logic        IF_to_IQ_valid;
    logic [64:0] IF_to_IQ_bus;
    logic        IQ_allow;
    logic        IQ_to_ID_valid;
    logic [64:0] IQ_to_ID_bus;
    logic        ID_allow;
    logic        WB_exception;
    logic        ertn_flush;
    logic        branch_valid;
    logic [2:0]  IQ_count;

    int errors = 0;
    int checks = 0;

    if_inst_queue #(.DEPTH(4)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .IF_to_IQ_valid (IF_to_IQ_valid),
        .IF_to_IQ_bus   (IF_to_IQ_bus),
        .IQ_allow       (IQ_allow),
        .IQ_to_ID_valid (IQ_to_ID_valid),
        .IQ_to_ID_bus   (IQ_to_ID_bus),
        .ID_allow       (ID_allow),
        .WB_exception   (WB_exception),
        .ertn_flush     (ertn_flush),
        .branch_valid   (branch_valid),
        .IQ_count       (IQ_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [64:0] pkt(input logic [31:0] pc, input logic [31:0] inst,
                                        input logic adef);
        return {inst, pc, adef};
    endfunction

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] BASE = 32'h1c00_0000;
    localparam logic [31:0] INST = 32'h0280_0c0c;

    initial begin
        resetn         = 1'b0;
        IF_to_IQ_valid = 1'b0;
        IF_to_IQ_bus   = '0;
        ID_allow       = 1'b0;
        WB_exception   = 1'b0;
        ertn_flush     = 1'b0;
        branch_valid   = 1'b0;

        // Reset held
        #2;
        chk("rst_allow", 65'(IQ_allow), 65'd0);
        chk("rst_valid", 65'(IQ_to_ID_valid), 65'd0);
        chk("rst_count", 65'(IQ_count), 65'd0);
        chk("rst_bus", IQ_to_ID_bus, 65'd0);
        #18 resetn = 1'b1;
        step();

        // 1: first packet, one-cycle latency
        chk("t1_allow", 65'(IQ_allow), 65'd1);
        chk("t1_count", 65'(IQ_count), 65'd0);
        chk("t1_valid0", 65'(IQ_to_ID_valid), 65'd0);
        IF_to_IQ_valid = 1'b1;
        IF_to_IQ_bus   = pkt(BASE, INST, 1'b0);
        ID_allow       = 1'b1;
        #1 chk("t1_no_bypass", 65'(IQ_to_ID_valid), 65'd0);
        step();
        IF_to_IQ_valid = 1'b0;
        #1;
        chk("t1_valid1", 65'(IQ_to_ID_valid), 65'd1);
        chk("t1_bus", IQ_to_ID_bus, pkt(BASE, INST, 1'b0));
        step();
        chk("t1_drained", 65'(IQ_count), 65'd0);

        // 2: fill to DEPTH, reject 5th, drain in order
        ID_allow = 1'b0;
        for (int i = 0; i < 4; i++) begin
            IF_to_IQ_valid = 1'b1;
            IF_to_IQ_bus   = pkt(BASE + 32'(4 * i), INST + 32'(i), 1'b0);
            step();
        end
        chk("t2_full_count", 65'(IQ_count), 65'd4);
        chk("t2_full_allow", 65'(IQ_allow), 65'd0);
        IF_to_IQ_bus = pkt(BASE + 32'h10, INST, 1'b0);
        step();
        chk("t2_5th_rejected", 65'(IQ_count), 65'd4);
        IF_to_IQ_valid = 1'b0;
        ID_allow       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_drain_valid", 65'(IQ_to_ID_valid), 65'd1);
            chk("t2_drain_bus", IQ_to_ID_bus, pkt(BASE + 32'(4 * i), INST + 32'(i), 1'b0));
            step();
            if (i == 0) chk("t2_allow_back", 65'(IQ_allow), 65'd1);
        end
        chk("t2_empty", 65'(IQ_count), 65'd0);
        #1 chk("t2_empty_valid", 65'(IQ_to_ID_valid), 65'd0);

        // 3: steady push+pop at count=2 across pointer wrap
        ID_allow       = 1'b0;
        IF_to_IQ_valid = 1'b1;
        IF_to_IQ_bus   = pkt(BASE, INST, 1'b0);
        step();
        IF_to_IQ_bus   = pkt(BASE + 32'h4, INST, 1'b0);
        step();
        chk("t3_count2", 65'(IQ_count), 65'd2);
        ID_allow = 1'b1;
        for (int k = 0; k < 10; k++) begin
            IF_to_IQ_valid = (k < 8);
            IF_to_IQ_bus   = pkt(BASE + 32'(4 * (k + 2)), INST, 1'b0);
            #1;
            chk("t3_order", IQ_to_ID_bus, pkt(BASE + 32'(4 * k), INST, 1'b0));
            step();
            chk("t3_count", 65'(IQ_count), (k < 8) ? 65'd2 : 65'(9 - k));
        end
        IF_to_IQ_valid = 1'b0;

        // 4: branch flush with count=3
        ID_allow = 1'b0;
        for (int i = 0; i < 3; i++) begin
            IF_to_IQ_valid = 1'b1;
            IF_to_IQ_bus   = pkt(BASE + 32'h80 + 32'(4 * i), INST, 1'b0);
            step();
        end
        chk("t4_count3", 65'(IQ_count), 65'd3);
        branch_valid   = 1'b1;
        IF_to_IQ_bus   = pkt(BASE + 32'h40, INST, 1'b0);
        ID_allow       = 1'b1;
        #1 chk("t4_flush_valid", 65'(IQ_to_ID_valid), 65'd0);
        step();
        branch_valid   = 1'b0;
        IF_to_IQ_valid = 1'b0;
        #1;
        chk("t4_count0", 65'(IQ_count), 65'd0);
        chk("t4_dropped", 65'(IQ_to_ID_valid), 65'd0);
        IF_to_IQ_valid = 1'b1;
        IF_to_IQ_bus   = pkt(BASE + 32'h100, INST, 1'b0);
        step();
        IF_to_IQ_valid = 1'b0;
        #1;
        chk("t4_target_valid", 65'(IQ_to_ID_valid), 65'd1);
        chk("t4_target_bus", IQ_to_ID_bus, pkt(BASE + 32'h100, INST, 1'b0));
        step();

        // 5: simultaneous exception + ertn with count=2
        ID_allow = 1'b0;
        for (int i = 0; i < 2; i++) begin
            IF_to_IQ_valid = 1'b1;
            IF_to_IQ_bus   = pkt(BASE + 32'h200 + 32'(4 * i), INST, 1'b0);
            step();
        end
        IF_to_IQ_valid = 1'b0;
        chk("t5_count2", 65'(IQ_count), 65'd2);
        WB_exception = 1'b1;
        ertn_flush   = 1'b1;
        ID_allow     = 1'b1;
        #1 chk("t5_no_pop", 65'(IQ_to_ID_valid), 65'd0);
        step();
        WB_exception = 1'b0;
        ertn_flush   = 1'b0;
        chk("t5_count0", 65'(IQ_count), 65'd0);

        // 6: asynchronous reset mid-operation, then adef packet
        ID_allow = 1'b0;
        for (int i = 0; i < 3; i++) begin
            IF_to_IQ_valid = 1'b1;
            IF_to_IQ_bus   = pkt(BASE + 32'h300 + 32'(4 * i), INST, 1'b0);
            step();
        end
        IF_to_IQ_valid = 1'b0;
        chk("t6_count3", 65'(IQ_count), 65'd3);
        #2 resetn = 1'b0;
        #1;
        chk("t6_rst_valid", 65'(IQ_to_ID_valid), 65'd0);
        chk("t6_rst_allow", 65'(IQ_allow), 65'd0);
        chk("t6_rst_count", 65'(IQ_count), 65'd0);
        step();
        #3 resetn = 1'b1;
        step();
        chk("t6_after_count", 65'(IQ_count), 65'd0);
        chk("t6_after_valid", 65'(IQ_to_ID_valid), 65'd0);
        chk("t6_after_allow", 65'(IQ_allow), 65'd1);
        IF_to_IQ_valid = 1'b1;
        IF_to_IQ_bus   = pkt(BASE + 32'h2, INST, 1'b1);
        step();
        IF_to_IQ_valid = 1'b0;
        #1;
        chk("t6_adef_valid", 65'(IQ_to_ID_valid), 65'd1);
        chk("t6_adef_bit", 65'(IQ_to_ID_bus[0]), 65'd1);
        chk("t6_adef_bus", IQ_to_ID_bus, pkt(BASE + 32'h2, INST, 1'b1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
